// File: rtl/vend_key_master_if.sv
// vend_key_master_if: Avalon-MM single-beat write bus from the key master to the vending slave
interface vend_key_master_if;
  logic       av_chipselect;
  logic       av_write;
  logic [3:0] av_address;
  logic [7:0] av_writedata;
  logic       av_waitrequest;
  modport master(output av_chipselect, av_write, av_address, av_writedata, input av_waitrequest);
  modport slave(input av_chipselect, av_write, av_address, av_writedata, output av_waitrequest);
endinterface

// File: rtl/vend_key_master.sv
// vend_key_master: debounced board keys turned into Avalon-MM set/clear register writes
module vend_key_master #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          key_kind,
  input  logic [2:0]          key_coin,
  input  logic                key_cancel,
  input  logic                key_sure,
  input  logic                key_done,
  vend_key_master_if.master   av,
  output logic                busy,
  output logic                dropped,
  output logic [7:0]          evt_count
);
  typedef enum logic [2:0] {IDLE, SET, HOLD, CLR, CLRK} state_t;
  state_t state, nxt;
  logic [8:0] raw, s1, s2, lvl, lvl_q, pending, rise, clr, pend_eff, acc;
  logic [CNT_W-1:0] cnt [9];
  logic [CNT_W-1:0] hcnt;
  logic [3:0] job, win, set_addr;
  logic [7:0] set_data;
  logic wr;
  // bit index doubles as arbitration priority: cancel highest, kind[2] lowest
  assign raw = {key_cancel, key_done, key_sure, key_coin, key_kind[0], key_kind[1], key_kind[2]};
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 9; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      lvl_q <= lvl;
      for (int i = 0; i < 9; i++)
        if (s2[i] != lvl[i]) begin
          lvl[i] <= cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1) ? s2[i] : lvl[i];
          cnt[i] <= cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1) ? '0 : cnt[i] + 1'b1;
        end else cnt[i] <= '0;
    end
  // a bit being retired this cycle counts as free, so a fresh press re-arms it
  assign rise = lvl & ~lvl_q;
  assign clr = (state == SET && !av.av_waitrequest) ? 9'd1 << job : '0;
  assign pend_eff = pending & ~clr;
  assign acc = rise & ~pend_eff;
  always_ff @(posedge clk)
    if (reset) begin
      pending <= '0;
      evt_count <= '0;
      dropped <= 1'b0;
    end else begin
      pending <= pend_eff | rise;
      evt_count <= evt_count + 8'($countones(acc));
      dropped <= dropped | (|(rise & pend_eff));
    end
  always_comb begin
    win = '0;
    for (int i = 0; i < 9; i++) win = pending[i] ? 4'(i) : win;
  end
  assign set_addr = job == 4'd8 ? 4'd2 : job == 4'd7 ? 4'd4 : job == 4'd6 ? 4'd3 : job >= 4'd3 ? 4'd1 : 4'd0;
  assign set_data = job >= 4'd6 ? 8'd1 : job >= 4'd3 ? 8'd1 << (job - 4'd3) : 8'd1 << (4'd2 - job);
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      job <= '0;
      hcnt <= '0;
    end else begin
      state <= nxt;
      job <= state == IDLE ? win : job;
      hcnt <= state == HOLD ? hcnt + 1'b1 : '0;
    end
  always_comb begin
    nxt = state;
    wr = 1'b0;
    av.av_address = '0;
    av.av_writedata = '0;
    case (state)
      IDLE: nxt = |pending ? SET : IDLE;
      SET: begin
        wr = 1'b1;
        av.av_address = set_addr;
        av.av_writedata = set_data;
        nxt = av.av_waitrequest ? SET : job <= 4'd2 ? IDLE : HOLD;
      end
      HOLD: nxt = hcnt == CNT_W'(HOLD_CYCLES - 1) ? CLR : HOLD;
      CLR: begin
        wr = 1'b1;
        av.av_address = set_addr;
        nxt = av.av_waitrequest ? CLR : job == 4'd7 ? CLRK : IDLE;
      end
      CLRK: begin
        wr = 1'b1;
        nxt = av.av_waitrequest ? CLRK : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  assign av.av_chipselect = wr;
  assign av.av_write = wr;
  assign busy = state != IDLE;
endmodule
